// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, LSB first, no parity, one stop bit.
// The pin is double-flopped; every decision is taken on the synchronized line.
// Each bit is sampled mid-bit, and the stop bit is sampled in the middle too.
// This leaves half a bit period free, so back-to-back frames are received.

module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 208
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] Half    = CntW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StStart    = 3'd1;
  localparam logic [2:0] StData     = 3'd2;
  localparam logic [2:0] StStop     = 3'd3;
  localparam logic [2:0] StCleanup  = 3'd4;
  localparam logic [2:0] StWaitHigh = 3'd5;

  logic            rx_meta_q, rx_s_q;
  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            dv_q, dv_d;
  logic            ferr_q, ferr_d;
  logic            active_q, active_d;

  // Two-flop synchronizer. It resets to the idle (high) line level.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Frame sequencing: start-bit check, data sampling, stop-bit verdict.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    dv_d      = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      StIdle: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (!rx_s_q) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (clk_cnt_q == Half) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          // The line is high again at mid start bit, so the low was a glitch.
          state_d   = rx_s_q ? StIdle : StData;
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end

      StData: begin
        if (clk_cnt_q == LastCnt) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end

      StStop: begin
        if (clk_cnt_q == LastCnt) begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = StCleanup;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitHigh;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end

      StCleanup: begin
        state_d = StIdle;
      end

      // Hold off until the line is released, so a held-low line cannot start a frame.
      StWaitHigh: begin
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d   = StIdle;
        clk_cnt_d = '0;
        bit_idx_d = '0;
      end
    endcase

    active_d = (state_d != StIdle);
  end

  // State and output registers.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      ferr_q    <= ferr_d;
      active_q  <= active_d;
    end
  end

  assign o_Rx_DV        = dv_q;
  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Frame_Err = ferr_q;
  assign o_Rx_Active    = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit.
// A timing model derived from the sample-point offsets predicts every output, every cycle.
// A byte scoreboard and directed literal checks cover each scenario.

module tb_uart_rx;

  localparam int Cpb  = 16;
  localparam int Half = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_pin = 1'b1;
  logic       o_Rx_DV, o_Rx_Frame_Err, o_Rx_Active;
  logic [7:0] o_Rx_Byte;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Monitor bookkeeping.
  int         dv_cnt = 0, ferr_cnt = 0, last_ferr_cyc = 0;
  int         dv_cyc_q[$];
  logic [7:0] dv_byte_q[$];
  logic [7:0] sent_q[$];
  bit         active_seen = 1'b0;
  int         tx_start = 0;

  // Model state.
  int         m_mode = 0;   // 0 idle, 1 in frame, 2 byte just delivered, 3 line held low
  int         m_c = 0;
  logic [7:0] m_bits = 8'h00;
  logic       d1 = 1'b1, d2 = 1'b1, rxs;
  logic       exp_dv = 1'b0, exp_ferr = 1'b0, exp_active = 1'b0;
  logic [7:0] exp_byte = 8'h00;
  logic       n_dv, n_ferr, n_active;
  logic [7:0] n_byte;
  int         off, k;

  uart_rx #(.CLKS_PER_BIT(Cpb)) dut (
    .i_Clock       (clk),
    .i_Rst_L       (rst_n),
    .i_Rx_Serial   (rx_pin),
    .o_Rx_DV       (o_Rx_DV),
    .o_Rx_Byte     (o_Rx_Byte),
    .o_Rx_Frame_Err(o_Rx_Frame_Err),
    .o_Rx_Active   (o_Rx_Active)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bench transmitter. It is called just after a rising edge and leaves the pin at the stop level.
  task automatic send(input logic [7:0] b, input logic stop_bit, input int start_len,
                      input bit good);
    if (good) sent_q.push_back(b);
    rx_pin   = 1'b0;
    tx_start = cyc;
    tick(start_len);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      tick(Cpb);
    end
    rx_pin = stop_bit;
    tick(Cpb);
  endtask

  // Compare and model process, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("outputs in reset", {o_Rx_DV, o_Rx_Frame_Err, o_Rx_Active, o_Rx_Byte}, 32'h0);
      m_mode = 0; exp_dv = 0; exp_ferr = 0; exp_active = 0; exp_byte = 8'h00;
      d1 = 1'b1; d2 = 1'b1;
    end else begin
      chk($sformatf("dv,ferr,active,byte @%0d", cyc),
          {o_Rx_DV, o_Rx_Frame_Err, o_Rx_Active, o_Rx_Byte},
          {exp_dv, exp_ferr, exp_active, exp_byte});
      if (o_Rx_DV) begin
        dv_cnt++;
        dv_cyc_q.push_back(cyc);
        dv_byte_q.push_back(o_Rx_Byte);
        if (sent_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected dv: got byte 0x%0h, expected no strobe", o_Rx_Byte);
        end else begin
          chk("scoreboard byte", o_Rx_Byte, sent_q.pop_front());
        end
      end
      if (o_Rx_Frame_Err) begin
        ferr_cnt++;
        last_ferr_cyc = cyc;
      end
      if (o_Rx_Active) active_seen = 1'b1;

      // Model: the synchronized line is the pin delayed two cycles. Samples fall at fixed
      // offsets from the detect cycle.
      rxs = d2;
      n_dv = 1'b0; n_ferr = 1'b0; n_active = exp_active; n_byte = exp_byte;
      case (m_mode)
        0: if (!rxs) begin m_mode = 1; m_c = cyc; n_active = 1'b1; end
        1: begin
          off = cyc - (m_c + 1 + Half);
          if (off == 0) begin
            if (rxs) begin m_mode = 0; n_active = 1'b0; end
          end else if (off > 0 && off % Cpb == 0) begin
            k = off / Cpb - 1;
            if (k < 8) m_bits[k] = rxs;
            else if (rxs) begin n_dv = 1'b1; n_byte = m_bits; m_mode = 2; end
            else begin n_ferr = 1'b1; m_mode = 3; end
          end
        end
        2: begin m_mode = 0; n_active = 1'b0; end
        default: if (rxs) begin m_mode = 0; n_active = 1'b0; end
      endcase
      d2 = d1;
      d1 = rx_pin;
      exp_dv = n_dv; exp_ferr = n_ferr; exp_active = n_active; exp_byte = n_byte;
    end
  end

  initial begin
    int base_dv, base_fe, s0, p;

    // Reset state.
    tick(3);
    chk("reset byte", o_Rx_Byte, 8'h00);
    chk("reset dv/ferr/active", {o_Rx_DV, o_Rx_Frame_Err, o_Rx_Active}, 3'b000);
    rst_n = 1'b1;
    tick(5);

    // Clean frame 0xA5 with idle line around it.
    base_dv = dv_cnt; base_fe = ferr_cnt;
    send(8'hA5, 1'b1, Cpb, 1'b1);
    s0 = tx_start;
    tick(20);
    chk("A5 dv count", dv_cnt - base_dv, 1);
    chk("A5 dv latency", dv_cyc_q[dv_cyc_q.size()-1] - s0, 155);
    chk("A5 byte", o_Rx_Byte, 8'hA5);
    chk("A5 no frame err", ferr_cnt - base_fe, 0);

    // Three-clock glitch, then a real frame 0x3C.
    base_dv = dv_cnt; base_fe = ferr_cnt; active_seen = 1'b0;
    rx_pin = 1'b0;
    tick(3);
    rx_pin = 1'b1;
    tick(30);
    chk("glitch active pulsed", active_seen, 1);
    chk("glitch active cleared", o_Rx_Active, 0);
    chk("glitch no dv/ferr", (dv_cnt - base_dv) + (ferr_cnt - base_fe), 0);
    send(8'h3C, 1'b1, Cpb, 1'b1);
    tick(20);
    chk("post-glitch dv count", dv_cnt - base_dv, 1);
    chk("post-glitch byte", o_Rx_Byte, 8'h3C);

    // Good 0x5A, then 0x3C with a low stop bit and the line held low.
    send(8'h5A, 1'b1, Cpb, 1'b1);
    tick(10);
    base_dv = dv_cnt; base_fe = ferr_cnt;
    send(8'h3C, 1'b0, Cpb, 1'b0);
    s0 = tx_start;
    tick(40);
    rx_pin = 1'b1;
    p = cyc;
    tick(2);
    chk("ferr active at pin-high+2", o_Rx_Active, 1);
    tick(1);
    chk("ferr active at pin-high+3", o_Rx_Active, 0);
    tick(10);
    chk("ferr pulse count", ferr_cnt - base_fe, 1);
    chk("ferr latency", last_ferr_cyc - s0, 155);
    chk("ferr no dv", dv_cnt - base_dv, 0);
    chk("ferr byte kept", o_Rx_Byte, 8'h5A);
    chk("ferr release time", cyc - p, 13);

    // Back-to-back 0x00 and 0xFF.
    base_dv = dv_cnt;
    send(8'h00, 1'b1, Cpb, 1'b1);
    send(8'hFF, 1'b1, Cpb, 1'b1);
    tick(20);
    chk("b2b dv count", dv_cnt - base_dv, 2);
    if (dv_cyc_q.size() >= 2) begin
      chk("b2b spacing", dv_cyc_q[dv_cyc_q.size()-1] - dv_cyc_q[dv_cyc_q.size()-2], 160);
      chk("b2b first byte", dv_byte_q[dv_byte_q.size()-2], 8'h00);
      chk("b2b second byte", dv_byte_q[dv_byte_q.size()-1], 8'hFF);
    end

    // Reset in the middle of the data bits of 0x81, then 0x42.
    base_dv = dv_cnt;
    fork
      send(8'h81, 1'b1, Cpb, 1'b0);
      begin
        tick(60);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset outputs", {o_Rx_DV, o_Rx_Frame_Err, o_Rx_Active, o_Rx_Byte}, 32'h0);
      end
    join
    tick(5);
    rst_n = 1'b1;
    tick(5);
    chk("no dv for aborted 0x81", dv_cnt - base_dv, 0);
    send(8'h42, 1'b1, Cpb, 1'b1);
    tick(20);
    chk("after reset dv count", dv_cnt - base_dv, 1);
    chk("after reset byte", o_Rx_Byte, 8'h42);

    // Sweep of all byte values. The start bit length is varied by -1/0/+1 clocks.
    base_dv = dv_cnt;
    for (int b = 0; b < 256; b++) begin
      send(8'(b), 1'b1, Cpb + (b % 3) - 1, 1'b1);
      tick(2);
    end
    tick(20);
    chk("sweep dv count", dv_cnt - base_dv, 256);
    chk("scoreboard drained", sent_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
